// File: rtl/hex_fragment_addr_gen_if.sv
// Hex fragment stream interface.
// Purpose: bundles the upstream hex handshake (valid_in/in_ready/q/r) and the
//          downstream fragment handshake (out_valid/out_ready/out_addr/out_col/out_row).
// Modports:
//   master - the side that produces hexes and consumes fragments (upstream + pixel writer)
//   slave  - the address generator itself
interface hex_fragment_addr_gen_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              valid_in;
    logic              in_ready;
    logic [31:0]       q;
    logic [31:0]       r;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_col;
    logic [15:0]       out_row;

    modport master (
        output valid_in, q, r, out_ready,
        input  in_ready, out_valid, out_addr, out_col, out_row
    );

    modport slave (
        input  valid_in, q, r, out_ready,
        output in_ready, out_valid, out_addr, out_col, out_row
    );
endinterface

// File: rtl/hex_fragment_addr_gen.sv
// Hex fragment address generator.
// Purpose: converts axial hex coords (q,r) to odd-r offset coords (col,row), culls
//          hexes outside the GRID_W x GRID_H framebuffer, computes the linear
//          framebuffer address and buffers results in a show-ahead FIFO.
// Ports:
//   clk          - clock, all state on posedge
//   reset        - asynchronous active-high reset
//   bus          - slave side of hex_fragment_addr_gen_if (input hexes, output fragments)
//   frag_count   - saturating count of in-bounds fragments pushed into the FIFO
//   culled_count - saturating count of out-of-bounds hexes dropped
module hex_fragment_addr_gen #(
    parameter int unsigned GRID_W     = 64,
    parameter int unsigned GRID_H     = 64,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_fragment_addr_gen_if.slave  bus,
    output logic [CNT_W-1:0]        frag_count,
    output logic [CNT_W-1:0]        culled_count
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 2;
    localparam int unsigned EW = ADDR_W + 32;

    // Stage 1 registers
    logic        s1_valid;
    logic        s1_inb;
    logic [31:0] s1_col;
    logic [31:0] s1_row;

    // Stage 2 registers
    logic          s2_valid;
    logic          s2_inb;
    logic [EW-1:0] s2_entry;

    // FIFO
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic [32:0]       col_calc;
    logic              inb_calc;
    logic [ADDR_W-1:0] addr_calc;
    logic              accept;
    logic              push;
    logic              pop;

    // 33-bit signed add: q + floor(r/2), both operands sign-extended.
    assign col_calc = {bus.q[31], bus.q} + {bus.r[31], bus.r[31], bus.r[31:1]};
    assign inb_calc = !col_calc[32] && (col_calc[31:0] < GRID_W) &&
                      !bus.r[31] && (bus.r < GRID_H);
    assign addr_calc = ADDR_W'(BASE_ADDR) + ADDR_W'(s1_row * GRID_W) + ADDR_W'(s1_col);

    // Culled hexes keep their credit until S2, so the FIFO can never overflow.
    assign bus.in_ready = (CW'(count) + CW'(s1_valid) + CW'(s2_valid)) < CW'(FIFO_DEPTH);
    assign accept       = bus.valid_in && bus.in_ready;
    assign push         = s2_valid && s2_inb;
    assign pop          = (count != '0) && bus.out_ready;

    assign bus.out_valid = (count != '0);
    assign {bus.out_addr, bus.out_col, bus.out_row} = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_inb       <= 1'b0;
            s1_col       <= '0;
            s1_row       <= '0;
            s2_valid     <= 1'b0;
            s2_inb       <= 1'b0;
            s2_entry     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frag_count   <= '0;
            culled_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_inb <= inb_calc;
                s1_col <= col_calc[31:0];
                s1_row <= bus.r;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inb   <= s1_inb;
                s2_entry <= {addr_calc, s1_col[15:0], s1_row[15:0]};
            end

            if (push) begin
                mem[wr_ptr] <= s2_entry;
                wr_ptr      <= wr_ptr + 1'b1;
                if (frag_count != '1) begin
                    frag_count <= frag_count + 1'b1;
                end
            end
            if (s2_valid && !s2_inb && (culled_count != '1)) begin
                culled_count <= culled_count + 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
